// File: rtl/ctrl_pipe.sv
// Generic control-bundle pipeline: STAGES registers of {valid, ctrl, rd, reg_write}
// with back-propagating stall, per-stage flush and a two-port in-flight hazard lookup.
module ctrl_pipe #(
    parameter int STAGES = 3,
    parameter int CTRL_W = 16,
    parameter int RD_W   = 5,
    parameter int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RD_W-1:0]          in_rd,
    input  logic                     in_reg_write,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*CTRL_W-1:0] stage_ctrl,
    output logic [STAGES*RD_W-1:0]   stage_rd,
    output logic [STAGES-1:0]        stage_reg_write,
    input  logic [RD_W-1:0]          query_rs1,
    input  logic [RD_W-1:0]          query_rs2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [IDX_W-1:0]         hit1_stage,
    output logic [IDX_W-1:0]         hit2_stage,
    output logic [OCC_W-1:0]         occupancy
);

    logic [STAGES-1:0]             valid_q, valid_d, rw_q, rw_d;
    logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [STAGES-1:0][RD_W-1:0]   rd_q, rd_d;

    logic [STAGES-1:0]             hold, hold_prev;
    logic                          hold_acc;
    logic [STAGES-1:0]             src_valid, src_rw;
    logic [STAGES-1:0][CTRL_W-1:0] src_ctrl;
    logic [STAGES-1:0][RD_W-1:0]   src_rd;
    logic [CTRL_W-1:0]             in_ctrl_m;
    logic [RD_W-1:0]               in_rd_m;
    logic [OCC_W-1:0]              occ;

    // A stall anywhere freezes that stage and everything younger.
    always_comb begin
        hold     = '0;
        hold_acc = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            hold_acc = hold_acc | stall[i];
            hold[i]  = hold_acc;
        end
    end

    // Each stage's load source is the next-younger register; stage 0 takes decode.
    assign in_ctrl_m = in_valid ? in_ctrl : '0;
    assign in_rd_m   = in_valid ? in_rd : '0;
    assign hold_prev = STAGES'({hold, 1'b0});
    assign src_valid = STAGES'({valid_q, in_valid});
    assign src_rw    = STAGES'({rw_q, in_valid & in_reg_write});
    assign src_ctrl  = (STAGES*CTRL_W)'({ctrl_q, in_ctrl_m});
    assign src_rd    = (STAGES*RD_W)'({rd_q, in_rd_m});

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i] || (!hold[i] && hold_prev[i])) begin
                valid_d[i] = 1'b0;
                rw_d[i]    = 1'b0;
                ctrl_d[i]  = '0;
                rd_d[i]    = '0;
            end else if (!hold[i]) begin
                valid_d[i] = src_valid[i];
                rw_d[i]    = src_rw[i];
                ctrl_d[i]  = src_ctrl[i];
                rd_d[i]    = src_rd[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rw_q    <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
        end
    end

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit1       = 1'b0;
        hit2       = 1'b0;
        hit1_stage = '0;
        hit2_stage = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (valid_q[i] && rw_q[i] && (rd_q[i] == query_rs1) && (query_rs1 != '0)) begin
                hit1       = 1'b1;
                hit1_stage = IDX_W'(i);
            end
            if (valid_q[i] && rw_q[i] && (rd_q[i] == query_rs2) && (query_rs2 != '0)) begin
                hit2       = 1'b1;
                hit2_stage = IDX_W'(i);
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign in_ready        = ~hold[0];
    assign stage_valid     = valid_q;
    assign stage_ctrl      = ctrl_q;
    assign stage_rd        = rd_q;
    assign stage_reg_write = valid_q & rw_q;
    assign occupancy       = occ;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: STAGES=3 main instance plus STAGES=1 and STAGES=5
// instances with CTRL_W=8.
module tb_ctrl_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // STAGES=3 instance
    logic        m_v = 0, m_rw = 0, m_ready, m_hit1, m_hit2;
    logic [15:0] m_ctrl_in = 0;
    logic [4:0]  m_rd_in = 0, m_q1 = 0, m_q2 = 0;
    logic [2:0]  m_stall = 0, m_flush = 0, m_valid, m_rwo;
    logic [47:0] m_ctrl;
    logic [14:0] m_rd;
    logic [1:0]  m_h1s, m_h2s, m_occ;

    ctrl_pipe #(.STAGES(3), .CTRL_W(16), .RD_W(5)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(m_v), .in_ctrl(m_ctrl_in), .in_rd(m_rd_in),
        .in_reg_write(m_rw), .in_ready(m_ready), .stall(m_stall), .flush(m_flush),
        .stage_valid(m_valid), .stage_ctrl(m_ctrl), .stage_rd(m_rd),
        .stage_reg_write(m_rwo), .query_rs1(m_q1), .query_rs2(m_q2), .hit1(m_hit1),
        .hit2(m_hit2), .hit1_stage(m_h1s), .hit2_stage(m_h2s), .occupancy(m_occ)
    );

    // STAGES=1 instance
    logic       a_v = 0, a_rw = 0, a_ready, a_hit1, a_hit2, a_h1s, a_h2s, a_occ;
    logic [7:0] a_ctrl_in = 0, a_ctrl;
    logic [4:0] a_rd_in = 0, a_rd;
    logic       a_stall = 0, a_flush = 0, a_valid, a_rwo;

    ctrl_pipe #(.STAGES(1), .CTRL_W(8), .RD_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(a_v), .in_ctrl(a_ctrl_in), .in_rd(a_rd_in),
        .in_reg_write(a_rw), .in_ready(a_ready), .stall(a_stall), .flush(a_flush),
        .stage_valid(a_valid), .stage_ctrl(a_ctrl), .stage_rd(a_rd),
        .stage_reg_write(a_rwo), .query_rs1(5'd0), .query_rs2(5'd0), .hit1(a_hit1),
        .hit2(a_hit2), .hit1_stage(a_h1s), .hit2_stage(a_h2s), .occupancy(a_occ)
    );

    // STAGES=5 instance
    logic        b_v = 0, b_rw = 0, b_ready, b_hit1, b_hit2;
    logic [7:0]  b_ctrl_in = 0;
    logic [4:0]  b_rd_in = 0, b_stall = 0, b_flush = 0, b_valid, b_rwo;
    logic [39:0] b_ctrl;
    logic [24:0] b_rd;
    logic [2:0]  b_h1s, b_h2s, b_occ;

    ctrl_pipe #(.STAGES(5), .CTRL_W(8), .RD_W(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(b_v), .in_ctrl(b_ctrl_in), .in_rd(b_rd_in),
        .in_reg_write(b_rw), .in_ready(b_ready), .stall(b_stall), .flush(b_flush),
        .stage_valid(b_valid), .stage_ctrl(b_ctrl), .stage_rd(b_rd),
        .stage_reg_write(b_rwo), .query_rs1(5'd0), .query_rs2(5'd0), .hit1(b_hit1),
        .hit2(b_hit2), .hit1_stage(b_h1s), .hit2_stage(b_h2s), .occupancy(b_occ)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [15:0] c, input logic [4:0] rd, input logic rw);
        m_v = v; m_ctrl_in = c; m_rd_in = rd; m_rw = rw;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_valid", m_valid, 3'b000);
        check("rst_ctrl", m_ctrl, 48'h0);
        check("rst_rd", m_rd, 15'h0);
        check("rst_rw", m_rwo, 3'b000);
        check("rst_occ", m_occ, 2'd0);
        check("rst_ready", m_ready, 1'b1);
        check("rst_hit", {m_hit1, m_hit2, m_h1s, m_h2s}, 6'h0);

        // Streaming A, B, C
        drv(1, 16'hA001, 5'd5, 1); step();
        check("str_e1_valid", m_valid, 3'b001);
        check("str_e1_occ", m_occ, 2'd1);
        drv(1, 16'hB002, 5'd6, 1); step();
        drv(1, 16'hC003, 5'd7, 1); step();
        check("str_valid", m_valid, 3'b111);
        check("str_occ", m_occ, 2'd3);
        check("str_ctrl", m_ctrl, {16'hA001, 16'hB002, 16'hC003});
        check("str_rd", m_rd, {5'd5, 5'd6, 5'd7});
        check("str_ready", m_ready, 1'b1);

        // stall[1] with D presented: D not captured, stage 2 bubbles
        drv(1, 16'hD004, 5'd8, 1); m_stall = 3'b010; #1;
        check("stall_ready", m_ready, 1'b0);
        step();
        check("stall_valid", m_valid, 3'b011);
        check("stall_ctrl", m_ctrl, {16'h0, 16'hB002, 16'hC003});
        check("stall_rd", m_rd, {5'd0, 5'd6, 5'd7});
        m_stall = 3'b000; step();
        check("resend_rd", m_rd, {5'd6, 5'd7, 5'd8});

        // flush 011 while full: stage 2 still takes old stage 1
        m_flush = 3'b011; drv(1, 16'hE005, 5'd9, 0); step();
        m_flush = 3'b000; drv(0, 16'h0, 5'd0, 0);
        check("flush_valid", m_valid, 3'b100);
        check("flush_ctrl", m_ctrl, {16'hC003, 16'h0, 16'h0});
        check("flush_rd", m_rd, {5'd7, 5'd0, 5'd0});
        check("flush_rw", m_rwo, 3'b100);

        // Simultaneous stall[1]+flush[1]
        drv(1, 16'h1111, 5'd10, 0); step();
        drv(1, 16'h2222, 5'd11, 1); step();
        drv(1, 16'h3333, 5'd12, 1); step();
        check("full_rw", m_rwo, 3'b011);
        drv(0, 16'h0, 5'd0, 0); m_stall = 3'b010; m_flush = 3'b010; step();
        m_stall = 3'b000; m_flush = 3'b000;
        check("sf_valid", m_valid, 3'b001);
        check("sf_ctrl", m_ctrl, {16'h0, 16'h0, 16'h3333});

        // Hazard lookup: X(rd5,rw1) Y(rd5,rw0) Z(rd5,rw1)
        drv(1, 16'h0051, 5'd5, 1); step();
        drv(1, 16'h0052, 5'd5, 0); step();
        drv(1, 16'h0053, 5'd5, 1); step();
        drv(0, 16'h0, 5'd0, 0);
        m_q1 = 5'd5; m_q2 = 5'd0; #1;
        check("hz_hit1", {m_hit1, m_h1s}, {1'b1, 2'd0});
        check("hz_rs0", {m_hit2, m_h2s}, {1'b0, 2'd0});
        m_q2 = 5'd5; #1;
        check("hz_hit2", {m_hit2, m_h2s}, {1'b1, 2'd0});
        step();
        check("hz_s1", {m_hit1, m_h1s}, {1'b1, 2'd1});
        step();
        check("hz_s2", {m_hit2, m_h2s}, {1'b1, 2'd2});
        step();
        check("hz_empty", {m_hit1, m_occ}, {1'b0, 2'd0});
        drv(1, 16'h0060, 5'd5, 0); step();
        check("hz_rw0", {m_hit1, m_hit2}, 2'b00);
        drv(1, 16'h0061, 5'd0, 1); step();
        drv(0, 16'h0, 5'd0, 0);
        m_q1 = 5'd0; #1;
        check("hz_rd0", {m_hit1, m_rwo}, {1'b0, 3'b001});

        // Reset mid-stream with stall[2]
        drv(1, 16'h0071, 5'd1, 1); step();
        m_stall = 3'b100; rst = 1'b1; step();
        rst = 1'b0; drv(0, 16'h0, 5'd0, 0);
        check("mrst_state", {m_valid, m_rwo, m_occ}, 8'h0);
        check("mrst_data", {m_ctrl, m_rd}, 63'h0);
        check("mrst_ready_st", m_ready, 1'b0);
        m_stall = 3'b000; #1;
        check("mrst_ready", m_ready, 1'b1);

        // STAGES=1
        a_v = 1; a_ctrl_in = 8'h5A; a_rd_in = 5'd3; a_rw = 1; step();
        check("s1_load", {a_valid, a_ctrl, a_rwo, a_occ}, {1'b1, 8'h5A, 1'b1, 1'b1});
        a_ctrl_in = 8'h11; a_stall = 1; #1;
        check("s1_ready", a_ready, 1'b0);
        step();
        check("s1_hold", a_ctrl, 8'h5A);
        a_flush = 1; step();
        a_flush = 0; a_stall = 0; a_v = 0;
        check("s1_flush", {a_valid, a_ctrl}, 9'h0);

        // STAGES=5: latency then hold/bubble
        b_v = 1; b_ctrl_in = 8'hC3; b_rd_in = 5'd4; b_rw = 1; step();
        b_v = 0;
        check("s5_lat0", b_valid, 5'b00001);
        for (int k = 1; k < 5; k++) begin
            step();
            check("s5_lat", b_valid, 5'b00001 << k);
        end
        check("s5_ctrl", b_ctrl, {8'hC3, 32'h0});
        b_v = 1; b_ctrl_in = 8'h77; step();
        b_v = 0; step();
        check("s5_g1", b_valid, 5'b00010);
        b_stall = 5'b00100; step();
        b_stall = 5'b00000;
        check("s5_hold", {b_valid, b_ctrl}, {5'b00010, 24'h0, 8'h77, 8'h0});
        step();
        check("s5_resume", b_valid, 5'b00100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline carrying the decoded control bundle from decode through STAGES pipeline registers (exec, mem, wb for STAGES=3). Each stage register holds a valid bit, an opaque control word, the destination register index and its reg_write flag. Supports per-stage stall with automatic back-propagation, per-stage flush with bubble insertion, and a combinational two-port hazard/forwarding lookup across all in-flight stages. Replaces the fixed per-stage control bundles with a single generic block.

## Interface
Parameters:
- STAGES, 3, number of pipeline registers (≥1); index 0 youngest (exec), STAGES-1 oldest.
- CTRL_W, 16, width of opaque control word (result_src, mem_write, alu fields etc. packed by caller).
- RD_W, 5, destination register index width.
- IDX_W, $clog2(STAGES) (min 1), width of stage index outputs.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ctrl  in  CTRL_W  control word from decode.
- in_rd  in  RD_W  destination register.
- in_reg_write  in  1  instruction writes in_rd.
- in_ready  out  1  stage 0 accepts this cycle.
- stall  in  STAGES  per-stage hold request.
- flush  in  STAGES  per-stage invalidate request.
- stage_valid  out  STAGES  valid bit per stage.
- stage_ctrl  out  STAGES*CTRL_W  control word per stage, stage i at bits [i*CTRL_W +: CTRL_W].
- stage_rd  out  STAGES*RD_W  rd per stage, same packing.
- stage_reg_write  out  STAGES  qualified reg_write per stage (valid & reg_write).
- query_rs1, query_rs2  in  RD_W  source registers to check.
- hit1, hit2  out  1  an in-flight stage will write the queried register.
- hit1_stage, hit2_stage  out  IDX_W  youngest matching stage.
- occupancy  out  $clog2(STAGES+1)  number of valid stages.

## Operation
- hold[i] = OR of stall[j] for j ≥ i (an older stall freezes all younger stages).
- in_ready = ~hold[0].
- Per stage at each rising edge, first matching rule wins:
  - rst: valid=0, ctrl=0, rd=0, reg_write=0.
  - flush[i]: bubble (valid=0, ctrl=0, rd=0, reg_write=0); flush beats hold.
  - hold[i]: keep contents.
  - i>0 and hold[i-1]: bubble (previous stage did not advance).
  - load: stage 0 from in_* (bubble if in_valid=0); stage i from stage i-1 (bubbles propagate as bubbles).
- Bubble control word is all-zero; callers encode NOP as zero so mem_write/reg_write are inert.
- Hazard lookup (combinational): stage i matches rsN if valid[i] & reg_write[i] & rd[i]==rsN & rsN≠0. hitN = any match; hitN_stage = lowest matching index; 0 when no hit.
- occupancy = popcount(stage_valid), combinational.
- Instruction dropped by decode only via flush; a held in_valid with in_ready=0 is not captured and must be re-presented by decode.

## Timing
- Reset values: stage_valid=0, stage_ctrl=0, stage_rd=0, stage_reg_write=0, hit1=hit2=0, hit*_stage=0, occupancy=0, in_ready=1 (when stall=0).
- Latency: 1 cycle per stage; instruction accepted at edge N appears in stage i after edge N+i with no stalls.
- in_ready, hit*, occupancy respond in the same cycle to stall/query/state changes; no registered outputs beyond stage registers.
- Simultaneous stall[i] and flush[i]: stage i bubbles, younger stages hold.
- Flush of stage i with no stall: older stage i+1 still loads stage i's pre-edge contents.
- rst mid-stream clears all stages in one edge regardless of stall/flush.
- STAGES=1: hold[0]=stall[0]; no inter-stage bubble rule.

## Test plan
- Streaming: STAGES=3, inject A(rd=5,rw=1), B(rd=6), C(rd=7) on consecutive cycles -> A in stage 2 at edge 3, occupancy 3, in_ready stays 1.
- Stall: with A,B,C in stages 2,1,0, assert stall[1] one cycle -> stages 0,1 hold, stage 2 becomes bubble, in_ready=0 that cycle, D not captured.
- Flush: assert flush=3'b011 with stages full -> stages 0,1 invalid with ctrl=0 next edge, stage 2 loaded from old stage 1.
- Hazard: stages 0 and 2 both rd=5 rw=1, query_rs1=5 -> hit1=1, hit1_stage=0; query_rs2=0 -> hit2=0; stage with rw=0 and rd=5 alone -> no hit.
- Reset mid-operation: full pipeline with stall[2]=1, assert rst -> all outputs zero after one edge, occupancy=0.
- Parameter sweep: STAGES=1 and STAGES=5 with CTRL_W=8 -> latency equals STAGES, bubble/hold rules as above.
